// File: rtl/ysyx_23060236_rd_arbiter.sv
// Two-master (IFU burst / LSU single) AXI4 read-channel arbiter onto one slave port.
// One transaction owns the port from AR handshake through the final R beat; ties go round-robin.
module ysyx_23060236_rd_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  // IFU
  input  logic [ADDR_W-1:0] ifu_araddr,
  input  logic              ifu_arvalid,
  output logic              ifu_arready,
  input  logic [1:0]        ifu_arburst,
  input  logic [3:0]        ifu_arlen,
  output logic [DATA_W-1:0] ifu_rdata,
  output logic [1:0]        ifu_rresp,
  output logic              ifu_rlast,
  output logic              ifu_rvalid,
  input  logic              ifu_rready,
  // LSU
  input  logic [ADDR_W-1:0] lsu_araddr,
  input  logic              lsu_arvalid,
  output logic              lsu_arready,
  input  logic [2:0]        lsu_arsize,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic [1:0]        lsu_rresp,
  output logic              lsu_rvalid,
  input  logic              lsu_rready,
  // Slave
  output logic [ADDR_W-1:0] out_araddr,
  output logic              out_arvalid,
  input  logic              out_arready,
  output logic [1:0]        out_arburst,
  output logic [3:0]        out_arlen,
  output logic [2:0]        out_arsize,
  input  logic [DATA_W-1:0] out_rdata,
  input  logic [1:0]        out_rresp,
  input  logic              out_rlast,
  input  logic              out_rvalid,
  output logic              out_rready,
  output logic              proto_err
);

  typedef enum logic [1:0] {StIdle, StAr, StRData} state_e;

  state_e      r_state;
  state_e      w_state_nxt;
  logic        r_owner_lsu;
  logic        r_last_lsu;
  logic [3:0]  r_arlen;
  logic [3:0]  r_beat_cnt;
  logic        r_proto_err;

  logic        w_req;
  logic        w_grant_lsu;
  logic        w_rready_sel;
  logic        w_beat;

  assign w_req        = ifu_arvalid | lsu_arvalid;
  // On a tie the master that did not win last time gets the port.
  assign w_grant_lsu  = lsu_arvalid & (~ifu_arvalid | ~r_last_lsu);
  assign w_rready_sel = r_owner_lsu ? lsu_rready : ifu_rready;
  assign w_beat       = (r_state == StRData) & out_rvalid & w_rready_sel;

  assign ifu_rdata = out_rdata;
  assign ifu_rresp = out_rresp;
  assign ifu_rlast = out_rlast;
  assign lsu_rdata = out_rdata;
  assign lsu_rresp = out_rresp;
  assign proto_err = r_proto_err;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= StIdle;
      r_owner_lsu <= 1'b0;
      r_last_lsu  <= 1'b0;
      r_arlen     <= 4'd0;
      r_beat_cnt  <= 4'd0;
      r_proto_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == StIdle && w_req) begin
        r_owner_lsu <= w_grant_lsu;
        r_last_lsu  <= w_grant_lsu;
        r_arlen     <= w_grant_lsu ? 4'd0 : ifu_arlen;
      end
      if (r_state == StAr && out_arready) begin
        r_beat_cnt <= 4'd0;
      end
      if (w_beat) begin
        r_beat_cnt <= r_beat_cnt + 4'd1;
        // Early rlast, or the expected final beat arriving without rlast.
        if (out_rlast != (r_beat_cnt == r_arlen)) begin
          r_proto_err <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    out_arvalid = 1'b0;
    out_araddr  = '0;
    out_arburst = 2'b00;
    out_arlen   = 4'd0;
    out_arsize  = 3'd0;
    ifu_arready = 1'b0;
    lsu_arready = 1'b0;
    ifu_rvalid  = 1'b0;
    lsu_rvalid  = 1'b0;
    out_rready  = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_req) begin
          w_state_nxt = StAr;
        end
      end
      StAr: begin
        out_arvalid = 1'b1;
        if (r_owner_lsu) begin
          out_araddr  = lsu_araddr;
          out_arburst = 2'b01;
          out_arlen   = 4'd0;
          out_arsize  = lsu_arsize;
          lsu_arready = out_arready;
        end else begin
          out_araddr  = ifu_araddr;
          out_arburst = ifu_arburst;
          out_arlen   = ifu_arlen;
          out_arsize  = 3'b010;
          ifu_arready = out_arready;
        end
        if (out_arready) begin
          w_state_nxt = StRData;
        end
      end
      StRData: begin
        out_rready = w_rready_sel;
        if (r_owner_lsu) begin
          lsu_rvalid = out_rvalid;
        end else begin
          ifu_rvalid = out_rvalid;
        end
        if (w_beat && out_rlast) begin
          w_state_nxt = StIdle;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

endmodule

// File: tb/tb_ysyx_23060236_rd_arbiter.sv
// Bench for the read arbiter: a slave/master driver plus a transaction-level round-robin model.
module tb_ysyx_23060236_rd_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] ifu_araddr, lsu_araddr, out_araddr;
  logic        ifu_arvalid, ifu_arready, lsu_arvalid, lsu_arready;
  logic [1:0]  ifu_arburst, out_arburst;
  logic [3:0]  ifu_arlen, out_arlen;
  logic [2:0]  lsu_arsize, out_arsize;
  logic [31:0] ifu_rdata, lsu_rdata, out_rdata;
  logic [1:0]  ifu_rresp, lsu_rresp, out_rresp;
  logic        ifu_rlast, ifu_rvalid, ifu_rready, lsu_rvalid, lsu_rready;
  logic        out_arvalid, out_arready, out_rlast, out_rvalid, out_rready, proto_err;

  ysyx_23060236_rd_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clock(clock), .reset(reset),
    .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready),
    .ifu_arburst(ifu_arburst), .ifu_arlen(ifu_arlen), .ifu_rdata(ifu_rdata),
    .ifu_rresp(ifu_rresp), .ifu_rlast(ifu_rlast), .ifu_rvalid(ifu_rvalid),
    .ifu_rready(ifu_rready),
    .lsu_araddr(lsu_araddr), .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready),
    .lsu_arsize(lsu_arsize), .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp),
    .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready),
    .out_araddr(out_araddr), .out_arvalid(out_arvalid), .out_arready(out_arready),
    .out_arburst(out_arburst), .out_arlen(out_arlen), .out_arsize(out_arsize),
    .out_rdata(out_rdata), .out_rresp(out_rresp), .out_rlast(out_rlast),
    .out_rvalid(out_rvalid), .out_rready(out_rready), .proto_err(proto_err)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Transaction-level model state
  bit          model_last_lsu, model_err;
  bit          ifu_pend, lsu_pend;
  logic [31:0] v_ifu_addr, v_lsu_addr;
  logic [3:0]  v_ifu_len;
  logic [1:0]  v_ifu_burst;
  logic [2:0]  v_lsu_size;

  // Expectations and observations of the last transaction
  bit          exp_lsu;
  int          exp_len, exp_beats;
  logic [31:0] exp_addr;
  logic [2:0]  exp_size;
  logic [1:0]  exp_burst;
  bit          obs_lsu, obs_lat, obs_stable, obs_hs, obs_nonown, obs_idle, obs_tmo, obs_ar_rr;
  logic [31:0] o_addr;
  logic [3:0]  o_len;
  logic [2:0]  o_size;
  logic [1:0]  o_burst;
  logic [33:0] sent_q[$];
  logic [33:0] rx_q[$];

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    ifu_arvalid = 0; lsu_arvalid = 0; ifu_rready = 0; lsu_rready = 0;
    out_arready = 0; out_rvalid = 0; out_rlast = 0; out_rdata = 0; out_rresp = 0;
    ifu_araddr = 0; lsu_araddr = 0; ifu_arburst = 0; ifu_arlen = 0; lsu_arsize = 0;
  endtask

  task automatic model_reset();
    model_last_lsu = 0; model_err = 0; ifu_pend = 0; lsu_pend = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    repeat (2) cyc();
    reset = 0;
    model_reset();
  endtask

  // Runs one whole transaction: arbitration, AR (optionally stalled), R beats, back to idle.
  task automatic do_txn(input int stall, input bit toggle, input bit gaps, input int bad_last);
    int b, n, last_at;
    bit beat, tick, own_rv, own_rr, oth_rv;
    logic [33:0] cur;
    logic [33:0] got;
    if (ifu_pend && lsu_pend) exp_lsu = !model_last_lsu;
    else exp_lsu = lsu_pend;
    model_last_lsu = exp_lsu;
    exp_len   = exp_lsu ? 0 : int'(v_ifu_len);
    exp_addr  = exp_lsu ? v_lsu_addr : v_ifu_addr;
    exp_size  = exp_lsu ? v_lsu_size : 3'd2;
    exp_burst = exp_lsu ? 2'b01 : v_ifu_burst;
    last_at   = (bad_last < 0) ? exp_len : bad_last;
    exp_beats = last_at + 1;
    if (last_at != exp_len) model_err = 1;
    sent_q.delete(); rx_q.delete();
    obs_nonown = 0; obs_tmo = 0; obs_stable = 1; obs_ar_rr = 0;
    ifu_arvalid = ifu_pend; ifu_araddr = v_ifu_addr; ifu_arlen = v_ifu_len;
    ifu_arburst = v_ifu_burst;
    lsu_arvalid = lsu_pend; lsu_araddr = v_lsu_addr; lsu_arsize = v_lsu_size;
    out_arready = 0; out_rvalid = 0;
    cyc(); #1;
    obs_lat = (out_arvalid === 1'b1);
    o_addr = out_araddr; o_len = out_arlen; o_size = out_arsize; o_burst = out_arburst;
    obs_lsu = lsu_pend && (out_araddr === v_lsu_addr);
    for (int s = 0; s < stall; s++) begin
      if (out_rready !== 1'b0) obs_ar_rr = 1;
      cyc(); #1;
      if (out_araddr !== o_addr || out_arlen !== o_len || out_arsize !== o_size ||
          out_arburst !== o_burst || out_arvalid !== 1'b1 ||
          ifu_arready !== 1'b0 || lsu_arready !== 1'b0) obs_stable = 0;
    end
    out_arready = 1;
    #1;
    obs_hs = exp_lsu ? (lsu_arready === 1'b1 && ifu_arready === 1'b0)
                     : (ifu_arready === 1'b1 && lsu_arready === 1'b0);
    cyc();
    out_arready = 0;
    if (exp_lsu) begin lsu_pend = 0; lsu_arvalid = 0; end
    else begin ifu_pend = 0; ifu_arvalid = 0; end
    b = 0; n = 0; tick = 0;
    cur = {2'($urandom), 32'($urandom)};
    forever begin
      out_rvalid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      out_rresp = cur[33:32]; out_rdata = cur[31:0]; out_rlast = (b == last_at);
      tick = ~tick;
      if (exp_lsu) begin lsu_rready = toggle ? tick : 1'b1; ifu_rready = 1'($urandom); end
      else begin ifu_rready = toggle ? tick : 1'b1; lsu_rready = 1'($urandom); end
      #1;
      own_rv = exp_lsu ? lsu_rvalid : ifu_rvalid;
      own_rr = exp_lsu ? lsu_rready : ifu_rready;
      oth_rv = exp_lsu ? ifu_rvalid : lsu_rvalid;
      if (oth_rv !== 1'b0) obs_nonown = 1;
      if (own_rv === 1'b1 && own_rr) begin
        got = exp_lsu ? {lsu_rresp, lsu_rdata} : {ifu_rresp, ifu_rdata};
        rx_q.push_back(got);
      end
      beat = out_rvalid && (out_rready === 1'b1);
      if (beat) sent_q.push_back(cur);
      cyc();
      n++;
      if (beat && b == last_at) break;
      if (beat) begin b++; cur = {2'($urandom), 32'($urandom)}; end
      if (n > 300) begin obs_tmo = 1; break; end
    end
    out_rvalid = 0; out_rlast = 0; ifu_rready = 0; lsu_rready = 0;
    #1;
    obs_idle = (out_arvalid === 1'b0) && (ifu_arready === 1'b0) &&
               (lsu_arready === 1'b0) && (out_rready === 1'b0);
  endtask

  task automatic test_reset();
    reset = 1;
    idle_inputs();
    ifu_arvalid = 1; lsu_arvalid = 1; out_rvalid = 1; ifu_rready = 1; lsu_rready = 1;
    repeat (3) cyc();
    #1;
    checks++;
    if (out_arvalid !== 0 || ifu_arready !== 0 || lsu_arready !== 0) begin
      errors++;
      $display("FAIL reset_ar_hs: arvalid=%b ifu_rdy=%b lsu_rdy=%b want 0", out_arvalid,
               ifu_arready, lsu_arready);
    end
    checks++;
    if (ifu_rvalid !== 0 || lsu_rvalid !== 0 || out_rready !== 0) begin
      errors++;
      $display("FAIL reset_r_hs: ifu_rv=%b lsu_rv=%b out_rr=%b want 0", ifu_rvalid, lsu_rvalid,
               out_rready);
    end
    checks++;
    if (out_araddr !== 0 || out_arlen !== 0 || out_arsize !== 0 || out_arburst !== 0) begin
      errors++;
      $display("FAIL reset_payload: addr=%h len=%h size=%h burst=%h want 0", out_araddr,
               out_arlen, out_arsize, out_arburst);
    end
    checks++;
    if (proto_err !== 0) begin
      errors++; $display("FAIL reset_proto_err: got %b want 0", proto_err);
    end
    do_reset();
  endtask

  task automatic test_ifu_alone();
    ifu_pend = 1; v_ifu_addr = 32'h3000_0020; v_ifu_len = 4'd7; v_ifu_burst = 2'b01;
    do_txn(0, 0, 0, -1);
    checks++;
    if (obs_lat !== 1 || obs_lsu !== 0) begin
      errors++; $display("FAIL ifu_grant: lat_ok=%b lsu_owner=%b want 1/0", obs_lat, obs_lsu);
    end
    checks++;
    if (o_addr !== 32'h3000_0020 || o_len !== 4'd7 || o_size !== 3'd2 || o_burst !== 2'b01) begin
      errors++;
      $display("FAIL ifu_payload: addr=%h len=%0d size=%0d burst=%b want 30000020/7/2/01",
               o_addr, o_len, o_size, o_burst);
    end
    checks++;
    if (rx_q.size() != 8 || sent_q.size() != 8 || rx_q != sent_q) begin
      errors++;
      $display("FAIL ifu_beats: got %0d rx %0d sent want 8 matching", rx_q.size(), sent_q.size());
    end
    checks++;
    if (obs_nonown !== 0 || obs_idle !== 1 || obs_hs !== 1 || obs_tmo !== 0) begin
      errors++;
      $display("FAIL ifu_flow: lsu_rvalid_seen=%b idle=%b hs=%b tmo=%b want 0/1/1/0",
               obs_nonown, obs_idle, obs_hs, obs_tmo);
    end
    checks++;
    if (proto_err !== 0) begin
      errors++; $display("FAIL ifu_proto_err: got %b want 0", proto_err);
    end
  endtask

  task automatic test_lsu_alone();
    lsu_pend = 1; v_lsu_addr = 32'h8000_0004; v_lsu_size = 3'd2;
    do_txn(0, 0, 0, -1);
    checks++;
    if (obs_lsu !== 1 || o_addr !== 32'h8000_0004 || o_len !== 0 || o_burst !== 2'b01 ||
        o_size !== 3'd2) begin
      errors++;
      $display("FAIL lsu_payload: owner_lsu=%b addr=%h len=%0d burst=%b size=%0d", obs_lsu,
               o_addr, o_len, o_burst, o_size);
    end
    checks++;
    if (rx_q.size() != 1 || rx_q != sent_q || obs_nonown !== 0 || obs_idle !== 1) begin
      errors++;
      $display("FAIL lsu_beat: got %0d beats nonown=%b idle=%b want 1/0/1", rx_q.size(),
               obs_nonown, obs_idle);
    end
  endtask

  task automatic test_tie();
    bit want;
    do_reset();
    v_ifu_addr = 32'h3000_0100; v_ifu_len = 4'd3; v_ifu_burst = 2'b01;
    v_lsu_addr = 32'h8000_0010; v_lsu_size = 3'd2;
    ifu_pend = 1; lsu_pend = 1;
    for (int i = 0; i < 6; i++) begin
      want = (i % 2 == 0);
      do_txn(0, 0, 0, -1);
      checks++;
      if (obs_lsu !== want || obs_lat !== 1 || rx_q != sent_q || rx_q.size() != exp_beats) begin
        errors++;
        $display("FAIL tie_%0d: owner_lsu=%b lat=%b beats=%0d want lsu=%b beats=%0d", i,
                 obs_lsu, obs_lat, rx_q.size(), want, exp_beats);
      end
      if (!ifu_pend) ifu_pend = 1;
      if (!lsu_pend) lsu_pend = 1;
    end
    // Drain the leftover request so later tests start from clean arbitration.
    do_txn(0, 0, 0, -1);
    ifu_pend = 0; lsu_pend = 0;
  endtask

  task automatic test_stall();
    ifu_pend = 1; v_ifu_addr = 32'h3000_0200; v_ifu_len = 4'd7; v_ifu_burst = 2'b01;
    do_txn(5, 1, 0, -1);
    checks++;
    if (obs_stable !== 1 || obs_ar_rr !== 0) begin
      errors++;
      $display("FAIL stall_ar_stable: stable=%b rready_in_ar=%b want 1/0", obs_stable, obs_ar_rr);
    end
    checks++;
    if (rx_q.size() != 8 || sent_q.size() != 8 || rx_q != sent_q || obs_tmo !== 0) begin
      errors++;
      $display("FAIL stall_beats: got %0d rx %0d sent tmo=%b want 8 matching", rx_q.size(),
               sent_q.size(), obs_tmo);
    end
  endtask

  task automatic test_early_rlast();
    ifu_pend = 1; v_ifu_addr = 32'h3000_0300; v_ifu_len = 4'd7; v_ifu_burst = 2'b01;
    do_txn(0, 0, 0, 3);
    checks++;
    if (proto_err !== 1 || obs_idle !== 1 || rx_q.size() != 4) begin
      errors++;
      $display("FAIL early_rlast: proto_err=%b idle=%b beats=%0d want 1/1/4", proto_err,
               obs_idle, rx_q.size());
    end
    lsu_pend = 1; v_lsu_addr = 32'h8000_0300; v_lsu_size = 3'd1;
    do_txn(0, 0, 0, -1);
    repeat (3) cyc();
    checks++;
    if (proto_err !== 1) begin
      errors++; $display("FAIL proto_err_sticky: got %b want 1", proto_err);
    end
  endtask

  task automatic test_reset_mid();
    ifu_arvalid = 1; ifu_araddr = 32'h3000_0400; ifu_arlen = 4'd7; ifu_arburst = 2'b01;
    cyc();
    out_arready = 1;
    cyc();
    out_arready = 0; ifu_arvalid = 0; ifu_rready = 1; out_rvalid = 1;
    for (int i = 0; i < 3; i++) begin
      out_rdata = $urandom;
      cyc();
    end
    reset = 1;
    cyc();
    reset = 0;
    #1;
    checks++;
    if (out_arvalid !== 0 || out_rready !== 0 || ifu_rvalid !== 0 || lsu_rvalid !== 0 ||
        ifu_arready !== 0 || lsu_arready !== 0) begin
      errors++;
      $display("FAIL reset_mid_idle: arv=%b rr=%b ifu_rv=%b lsu_rv=%b want all 0", out_arvalid,
               out_rready, ifu_rvalid, lsu_rvalid);
    end
    checks++;
    if (proto_err !== 0) begin
      errors++; $display("FAIL reset_mid_proto_err: got %b want 0", proto_err);
    end
    idle_inputs();
    model_reset();
    v_ifu_addr = 32'h3000_0500; v_ifu_len = 4'd1; v_lsu_addr = 32'h8000_0500;
    ifu_pend = 1; lsu_pend = 1;
    do_txn(0, 0, 0, -1);
    checks++;
    if (obs_lsu !== 1) begin
      errors++; $display("FAIL reset_mid_tie: owner_lsu=%b want 1", obs_lsu);
    end
    do_txn(0, 0, 0, -1);
  endtask

  task automatic test_random();
    for (int t = 0; t < 40; t++) begin
      if (!ifu_pend && $urandom_range(0, 1) == 1) begin
        ifu_pend = 1;
        v_ifu_addr = 32'h3000_0000 | ($urandom & 32'h00ff_ffe0);
        v_ifu_len = 4'($urandom_range(0, 7)); v_ifu_burst = 2'($urandom_range(0, 2));
      end
      if (!lsu_pend && ($urandom_range(0, 1) == 1 || !ifu_pend)) begin
        lsu_pend = 1;
        v_lsu_addr = 32'h8000_0000 | ($urandom & 32'h0fff_fffc);
        v_lsu_size = 3'($urandom_range(0, 2));
      end
      do_txn($urandom_range(0, 3), 1'($urandom), 1'($urandom),
             ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 9)) : -1);
      checks++;
      if (obs_lsu !== exp_lsu || obs_lat !== 1 || obs_hs !== 1) begin
        errors++;
        $display("FAIL rand_%0d_grant: owner_lsu=%b lat=%b hs=%b want lsu=%b/1/1", t, obs_lsu,
                 obs_lat, obs_hs, exp_lsu);
      end
      checks++;
      if (o_addr !== exp_addr || o_len !== 4'(exp_len) || o_size !== exp_size ||
          o_burst !== exp_burst || obs_stable !== 1) begin
        errors++;
        $display("FAIL rand_%0d_payload: %h/%0d/%0d/%b want %h/%0d/%0d/%b", t, o_addr, o_len,
                 o_size, o_burst, exp_addr, exp_len, exp_size, exp_burst);
      end
      checks++;
      if (rx_q.size() != exp_beats || rx_q != sent_q || obs_nonown !== 0 || obs_tmo !== 0) begin
        errors++;
        $display("FAIL rand_%0d_data: got %0d beats nonown=%b tmo=%b want %0d", t, rx_q.size(),
                 obs_nonown, obs_tmo, exp_beats);
      end
      checks++;
      if (obs_idle !== 1 || proto_err !== model_err) begin
        errors++;
        $display("FAIL rand_%0d_end: idle=%b proto_err=%b want 1/%b", t, obs_idle, proto_err,
                 model_err);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ifu_alone();
    test_lsu_alone();
    test_tie();
    test_stall();
    test_early_rlast();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
